// File: rtl/ssd_pkg.sv
// ssd_pkg: shared definitions for the seven-segment scan slice.
//   NIBBLE_W  width of one hex digit
//   ANODE_OFF per-bit level that switches a common-anode digit off
//   nibble_t  one hex digit
//   idx_w()   index width that stays >= 1 for counts of 1 or 2
package ssd_pkg;
  localparam int NIBBLE_W = 4;
  localparam logic ANODE_OFF = '1;

  typedef logic [NIBBLE_W-1:0] nibble_t;

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/ssd_scan_if.sv
// ssd_scan_if: producer/display bundle of the scan driver.
//   data_in     packed nibbles, nibble 0 = rightmost digit
//   load        capture data_in this cycle
//   digit_value nibble of the digit currently selected
//   anode       active-low digit enables
//   digit_idx   index of the current slot
//   frame_start one-cycle pulse on the first cycle of slot 0
// master: data producer side; slave: ssd_scan.
interface ssd_scan_if #(
  parameter int DIGITS = 4
);
  import ssd_pkg::*;

  localparam int IDX_W = idx_w(DIGITS);

  logic [NIBBLE_W*DIGITS-1:0] data_in;
  logic                       load;
  nibble_t                    digit_value;
  logic [DIGITS-1:0]          anode;
  logic [IDX_W-1:0]           digit_idx;
  logic                       frame_start;

  modport master (
    output data_in, load,
    input  digit_value, anode, digit_idx, frame_start
  );

  modport slave (
    input  data_in, load,
    output digit_value, anode, digit_idx, frame_start
  );
endinterface

// File: rtl/ssd_refresh_tick.sv
// ssd_refresh_tick: digit-slot timer of the scan driver.
//   clk, rst_n  clock, asynchronous active-low reset
//   slot_cnt    position inside the slot, 0..REFRESH_DIV-1
//   slot_wrap   high on the last cycle of a slot
//   dead        high when the cycle after the coming edge lies in the dead time
module ssd_refresh_tick #(
  parameter int REFRESH_DIV = 100000,
  parameter int DEAD_CYCLES = 1000,
  parameter int CNT_W       = ssd_pkg::idx_w(REFRESH_DIV)
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [CNT_W-1:0] slot_cnt,
  output logic             slot_wrap,
  output logic             dead
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(REFRESH_DIV - 1);

  assign slot_wrap = (slot_cnt == LAST);

  // dead looks one cycle ahead so the registered anode in the top lines up with slot_cnt.
  always_comb begin
    dead = 1'b0;
    if (slot_wrap) dead = (DEAD_CYCLES > 0);
    else           dead = ((int'(slot_cnt) + 1) < DEAD_CYCLES);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         slot_cnt <= '0;
    else if (slot_wrap) slot_cnt <= '0;
    else                slot_cnt <= slot_cnt + CNT_W'(1);
  end
endmodule

// File: rtl/ssd_scan.sv
// ssd_scan: time-multiplexed driver for a common-anode multi-digit display.
//   clk    system clock
//   rst_n  asynchronous active-low reset, synchronous release
//   bus    ssd_scan_if.slave: data_in/load in; digit_value/anode/digit_idx/frame_start out
// A loaded word is parked in hold and copied to disp only at a frame boundary, so a
// frame never mixes old and new digits. Each slot opens with DEAD_CYCLES of all anodes off.
// Build option SSD_LZ_BLANK_EN: leading-zero blanking (digit 0 is always shown).
module ssd_scan #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int DEAD_CYCLES = 1000
) (
  input  logic      clk,
  input  logic      rst_n,
  ssd_scan_if.slave bus
);
  import ssd_pkg::*;

  localparam int IDX_W  = idx_w(DIGITS);
  localparam int CNT_W  = idx_w(REFRESH_DIV);
  localparam int WORD_W = NIBBLE_W * DIGITS;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  logic [CNT_W-1:0]  unused_slot_cnt;
  logic              slot_wrap;
  logic              dead;
  logic              frame_wrap;
  logic              show_p0;
  logic [IDX_W-1:0]  idx_p0, idx_p1;
  logic [WORD_W-1:0] disp_p0, disp_p1;
  logic [WORD_W-1:0] hold_p1;
  logic [DIGITS-1:0] anode_p0, anode_p1;
  nibble_t           digit_value_p1;
  logic              frame_start_p1;

  // Slot position is only needed inside the tick; the top acts on its strobes.
  ssd_refresh_tick #(
    .REFRESH_DIV (REFRESH_DIV),
    .DEAD_CYCLES (DEAD_CYCLES),
    .CNT_W       (CNT_W)
  ) u_tick (
    .clk       (clk),
    .rst_n     (rst_n),
    .slot_cnt  (unused_slot_cnt),
    .slot_wrap (slot_wrap),
    .dead      (dead)
  );

  // p0: next-state of the scan, evaluated ahead of the output register
  assign frame_wrap = slot_wrap && (idx_p1 == LAST_IDX);
  assign disp_p0    = frame_wrap ? hold_p1 : disp_p1;

  always_comb begin
    idx_p0 = idx_p1;
    if (frame_wrap)     idx_p0 = '0;
    else if (slot_wrap) idx_p0 = idx_p1 + IDX_W'(1);
  end

`ifdef SSD_LZ_BLANK_EN
  logic [DIGITS-1:0] blank_p0, blank_p1;

  function automatic logic [DIGITS-1:0] lz_flags(input logic [WORD_W-1:0] word);
    logic [DIGITS-1:0] flags;
    logic              zero_above;
    flags      = '0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_above = zero_above && (word[i*NIBBLE_W +: NIBBLE_W] == '0);
      flags[i]   = zero_above && (i != 0);
    end
    return flags;
  endfunction

  assign blank_p0 = frame_wrap ? lz_flags(hold_p1) : blank_p1;
  assign show_p0  = !dead && !blank_p0[idx_p0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) blank_p1 <= lz_flags('0);
    else        blank_p1 <= blank_p0;
  end
`else
  assign show_p0 = !dead;
`endif

  always_comb begin
    anode_p0 = {DIGITS{ANODE_OFF}};
    if (show_p0) anode_p0[idx_p0] = ~ANODE_OFF;
  end

  // p1: registered scan state and outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_p1        <= '0;
      disp_p1        <= '0;
      idx_p1         <= '0;
      digit_value_p1 <= '0;
      anode_p1       <= {DIGITS{ANODE_OFF}};
      frame_start_p1 <= 1'b0;
    end else begin
      if (bus.load) hold_p1 <= bus.data_in;
      disp_p1        <= disp_p0;
      idx_p1         <= idx_p0;
      if (slot_wrap) digit_value_p1 <= disp_p0[idx_p0*NIBBLE_W +: NIBBLE_W];
      anode_p1       <= anode_p0;
      frame_start_p1 <= frame_wrap;
    end
  end

  assign bus.digit_value = digit_value_p1;
  assign bus.anode       = anode_p1;
  assign bus.digit_idx   = idx_p1;
  assign bus.frame_start = frame_start_p1;
endmodule

// File: tb/tb_ssd_scan.sv
// tb_ssd_scan: directed bench for ssd_scan with DIGITS=4, REFRESH_DIV=8, DEAD_CYCLES=2.
// One frame is 32 cycles; each slot has 2 dead cycles then 6 driven cycles.
module tb_ssd_scan;
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  ssd_scan_if #(.DIGITS(4)) dut_if ();

  ssd_scan #(
    .DIGITS      (4),
    .REFRESH_DIV (8),
    .DEAD_CYCLES (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dut_if)
  );

`ifdef SSD_LZ_BLANK_EN
  localparam logic [15:0] ZERO_LOW   = 16'h0006;
  localparam logic [15:0] ZERO_FIRST = 16'hFFF2;
`else
  localparam logic [15:0] ZERO_LOW   = 16'h6666;
  localparam logic [15:0] ZERO_FIRST = 16'h2222;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int mon_err = 0;

  logic [15:0] obs_word, obs_low, obs_first;
  int          obs_glitch, obs_fs;
  logic [3:0]  prev_dv = 4'h0;

  // Watch every cycle: at most one anode low, digit_value moves only while all anodes are off.
  always @(negedge clk) begin
    if ($countones(~dut_if.anode) > 1 ||
        (dut_if.digit_value !== prev_dv && dut_if.anode !== 4'hF)) begin
      mon_err++;
      if (mon_err <= 5)
        $display("monitor violation t=%0t anode=%b digit_value=%h previous=%h",
                 $time, dut_if.anode, dut_if.digit_value, prev_dv);
    end
    prev_dv = dut_if.digit_value;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_fs(input string name);
    int k;
    k = 0;
    while (dut_if.frame_start !== 1'b1 && k < 64) begin
      tick();
      k++;
    end
    n_cmp++;
    if (dut_if.frame_start !== 1'b1) begin
      n_err++;
      $display("FAIL %s frame_start: none within %0d cycles, expected a pulse", name, k);
    end
  endtask

  // Observes one frame from its first cycle; optionally pulses load at position load_at.
  task automatic capture_frame(input int load_at, input logic [15:0] load_val);
    logic [3:0] want_an;
    int lows;
    int first;
    obs_glitch = 0;
    obs_fs     = 0;
    for (int s = 0; s < 4; s++) begin
      obs_word[s*4 +: 4] = dut_if.digit_value;
      want_an    = 4'hF;
      want_an[s] = 1'b0;
      lows       = 0;
      first      = 15;
      for (int c = 0; c < 8; c++) begin
        if (dut_if.digit_value !== obs_word[s*4 +: 4]) obs_glitch++;
        if (dut_if.digit_idx !== 2'(s)) obs_glitch++;
        if (dut_if.anode !== 4'hF) begin
          lows++;
          if (first == 15) first = c;
          if (dut_if.anode !== want_an) obs_glitch++;
        end
        if (dut_if.frame_start === 1'b1) obs_fs += (s == 0 && c == 0) ? 1 : 16;
        if (s * 8 + c == load_at) begin
          dut_if.load    = 1'b1;
          dut_if.data_in = load_val;
        end
        tick();
        dut_if.load = 1'b0;
      end
      obs_low[s*4 +: 4]   = 4'(lows);
      obs_first[s*4 +: 4] = 4'(first);
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (dut_if.anode !== 4'hF) begin n_err++; $display("FAIL reset_anode got=%b want=1111", dut_if.anode); end
    n_cmp++; if (dut_if.digit_value !== 4'h0) begin n_err++; $display("FAIL reset_value got=%h want=0", dut_if.digit_value); end
    n_cmp++; if (dut_if.frame_start !== 1'b0) begin n_err++; $display("FAIL reset_fs got=%b want=0", dut_if.frame_start); end
    n_cmp++; if (dut_if.digit_idx !== 2'd0) begin n_err++; $display("FAIL reset_idx got=%0d want=0", dut_if.digit_idx); end
    rst_n = 1'b1;
    n_cmp++; if (dut_if.anode !== 4'hF) begin n_err++; $display("FAIL release_c0 anode got=%b want=1111", dut_if.anode); end
    tick();
    n_cmp++; if (dut_if.anode !== 4'hF) begin n_err++; $display("FAIL release_c1 anode got=%b want=1111", dut_if.anode); end
    tick();
    n_cmp++; if (dut_if.anode !== 4'b1110) begin n_err++; $display("FAIL release_c2 anode got=%b want=1110", dut_if.anode); end
    n_cmp++; if (dut_if.digit_idx !== 2'd0) begin n_err++; $display("FAIL release_c2 idx got=%0d want=0", dut_if.digit_idx); end
  endtask

  task automatic test_frame();
    dut_if.data_in = 16'h1234;
    dut_if.load    = 1'b1;
    tick();
    dut_if.load = 1'b0;
    wait_fs("frame");
    capture_frame(-1, 16'h0);
    n_cmp++; if (obs_word !== 16'h1234) begin n_err++; $display("FAIL frame_digits got=%h want=1234", obs_word); end
    n_cmp++; if (obs_low !== 16'h6666) begin n_err++; $display("FAIL frame_low_cycles got=%h want=6666", obs_low); end
    n_cmp++; if (obs_first !== 16'h2222) begin n_err++; $display("FAIL frame_first_low got=%h want=2222", obs_first); end
    n_cmp++; if (obs_glitch !== 0) begin n_err++; $display("FAIL frame_glitch got=%0d want=0", obs_glitch); end
    n_cmp++; if (obs_fs !== 1) begin n_err++; $display("FAIL frame_fs_pulse got=%0d want=1", obs_fs); end
  endtask

  task automatic test_midframe_load();
    capture_frame(20, 16'hABCD);
    n_cmp++; if (obs_word !== 16'h1234) begin n_err++; $display("FAIL midload_same_frame got=%h want=1234", obs_word); end
    n_cmp++; if (obs_glitch !== 0) begin n_err++; $display("FAIL midload_tear got=%0d want=0", obs_glitch); end
    capture_frame(-1, 16'h0);
    n_cmp++; if (obs_word !== 16'hABCD) begin n_err++; $display("FAIL midload_next_frame got=%h want=abcd", obs_word); end
    n_cmp++; if (obs_glitch !== 0) begin n_err++; $display("FAIL midload_next_tear got=%0d want=0", obs_glitch); end
    n_cmp++; if (obs_fs !== 1) begin n_err++; $display("FAIL midload_fs got=%0d want=1", obs_fs); end
  endtask

  task automatic test_boundary_load();
    capture_frame(31, 16'h5555);
    n_cmp++; if (obs_word !== 16'hABCD) begin n_err++; $display("FAIL edge_load_frame0 got=%h want=abcd", obs_word); end
    capture_frame(-1, 16'h0);
    n_cmp++; if (obs_word !== 16'hABCD) begin n_err++; $display("FAIL edge_load_frame1 got=%h want=abcd", obs_word); end
    capture_frame(-1, 16'h0);
    n_cmp++; if (obs_word !== 16'h5555) begin n_err++; $display("FAIL edge_load_frame2 got=%h want=5555", obs_word); end
    n_cmp++; if (obs_low !== 16'h6666) begin n_err++; $display("FAIL edge_load_low got=%h want=6666", obs_low); end
  endtask

  task automatic test_back_to_back();
    dut_if.data_in = 16'h1111;
    dut_if.load    = 1'b1;
    tick();
    dut_if.data_in = 16'h2222;
    tick();
    dut_if.load = 1'b0;
    wait_fs("b2b");
    capture_frame(-1, 16'h0);
    n_cmp++; if (obs_word !== 16'h2222) begin n_err++; $display("FAIL b2b_last_wins got=%h want=2222", obs_word); end
    n_cmp++; if (obs_glitch !== 0) begin n_err++; $display("FAIL b2b_glitch got=%0d want=0", obs_glitch); end
  endtask

  task automatic test_reset_midframe();
    dut_if.data_in = 16'h9876;
    dut_if.load    = 1'b1;
    tick();
    dut_if.load = 1'b0;
    repeat (24) tick();
    n_cmp++; if (dut_if.digit_value !== 4'h2) begin n_err++; $display("FAIL pre_reset_value got=%h want=2", dut_if.digit_value); end
    n_cmp++; if (dut_if.anode !== 4'hF) begin n_err++; $display("FAIL pre_reset_dead got=%b want=1111", dut_if.anode); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (dut_if.anode !== 4'hF) begin n_err++; $display("FAIL async_anode got=%b want=1111", dut_if.anode); end
    n_cmp++; if (dut_if.digit_value !== 4'h0) begin n_err++; $display("FAIL async_value got=%h want=0", dut_if.digit_value); end
    n_cmp++; if (dut_if.digit_idx !== 2'd0) begin n_err++; $display("FAIL async_idx got=%0d want=0", dut_if.digit_idx); end
    n_cmp++; if (dut_if.frame_start !== 1'b0) begin n_err++; $display("FAIL async_fs got=%b want=0", dut_if.frame_start); end
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    n_cmp++; if (dut_if.anode !== 4'hF) begin n_err++; $display("FAIL restart_c1 anode got=%b want=1111", dut_if.anode); end
    tick();
    n_cmp++; if (dut_if.anode !== 4'b1110) begin n_err++; $display("FAIL restart_c2 anode got=%b want=1110", dut_if.anode); end
    wait_fs("restart");
    capture_frame(-1, 16'h0);
    n_cmp++; if (obs_word !== 16'h0000) begin n_err++; $display("FAIL restart_hold_lost got=%h want=0000", obs_word); end
    n_cmp++; if (obs_low !== ZERO_LOW) begin n_err++; $display("FAIL restart_low got=%h want=%h", obs_low, ZERO_LOW); end
    n_cmp++; if (obs_first !== ZERO_FIRST) begin n_err++; $display("FAIL restart_first got=%h want=%h", obs_first, ZERO_FIRST); end
  endtask

`ifdef SSD_LZ_BLANK_EN
  task automatic test_lz_blank();
    dut_if.data_in = 16'h0070;
    dut_if.load    = 1'b1;
    tick();
    dut_if.load = 1'b0;
    wait_fs("lz70");
    capture_frame(-1, 16'h0);
    n_cmp++; if (obs_word !== 16'h0070) begin n_err++; $display("FAIL lz70_digits got=%h want=0070", obs_word); end
    n_cmp++; if (obs_low !== 16'h0066) begin n_err++; $display("FAIL lz70_low got=%h want=0066", obs_low); end
    n_cmp++; if (obs_first !== 16'hFF22) begin n_err++; $display("FAIL lz70_first got=%h want=ff22", obs_first); end
    dut_if.data_in = 16'h0000;
    dut_if.load    = 1'b1;
    tick();
    dut_if.load = 1'b0;
    wait_fs("lz00");
    capture_frame(-1, 16'h0);
    n_cmp++; if (obs_low !== 16'h0006) begin n_err++; $display("FAIL lz00_low got=%h want=0006", obs_low); end
    n_cmp++; if (obs_first !== 16'hFFF2) begin n_err++; $display("FAIL lz00_first got=%h want=fff2", obs_first); end
  endtask
`endif

  task automatic test_monitor();
    n_cmp++;
    if (mon_err !== 0) begin
      n_err++;
      $display("FAIL monitor_rules violations=%0d want=0", mon_err);
    end
  endtask

  initial begin
    dut_if.data_in = '0;
    dut_if.load    = 1'b0;
    test_reset();
    test_frame();
    test_midframe_load();
    test_boundary_load();
    test_back_to_back();
    test_reset_midframe();
`ifdef SSD_LZ_BLANK_EN
    test_lz_blank();
`endif
    test_monitor();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
